instr_fetch_unit: RTL and testbench

- Front end of the 16-bit RISC core.
- Owns the program counter and fetches 16-bit instructions from instruction memory over a request/valid handshake.
- Presents the opcode and register fields to the opcode decoder (control unit).
- Consumes the decoder's registered pc_en/jmp back to advance or redirect the PC, closing the fetch/decode loop from the issuing side.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/instr_fetch_unit_pc_reg.sv | 36 +++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-state encoding, opcodes and instruction field positions
package core_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } fetch_state_e;

  localparam logic [3:0] OP_DIV = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_LD  = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1100;
  localparam logic [3:0] OP_LDI = 4'b1101;
  localparam logic [3:0] OP_BEQ = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// rtl/instr_fetch_unit_pc_reg.sv - program counter register with load, increment and natural wrap
module pc_reg #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Load wins over increment; the adder wraps all-ones back to zero.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch front end: PC, imem handshake, IR and field outputs
// Optional HALT state on a self-jump is enabled by defining HALT_ON_SELF_JUMP_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  input  logic              pc_en,
  input  logic              jmp,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic              instr_valid,
  output logic              exec_strobe,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  import core_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               pc_load;
  logic               pc_inc;
  logic [ADDR_W-1:0]  jmp_target;

  assign jmp_target = ir_q[ADDR_W-1:0];

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (jmp_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    exec_strobe = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      // Masking with rst keeps the strobe quiet while reset is held.
      ST_FETCH: begin
        if (!stall && !rst) begin
          imem_req = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        instr_valid = 1'b1;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        exec_strobe = 1'b1;
        state_d     = ST_FETCH;
        if (jmp) begin
`ifdef HALT_ON_SELF_JUMP_EN
          if (jmp_target == pc) begin
            state_d = ST_HALT;
          end else begin
            pc_load = 1'b1;
          end
`else
          pc_load = 1'b1;
`endif
        end else if (pc_en) begin
          pc_inc = 1'b1;
        end
      end
`ifdef HALT_ON_SELF_JUMP_EN
      ST_HALT: begin
        halted = 1'b1;
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir_q[OPC_HI:OPC_LO];
  assign rd        = ir_q[RD_HI:RD_LO];
  assign rs1       = ir_q[RS1_HI:RS1_LO];
  assign rs2       = ir_q[RS2_HI:RS2_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [15:0] imem_rdata;
  logic       pc_en;
  logic       jmp;
  logic [3:0] opcode, rd, rs1, rs2;
  logic       instr_valid;
  logic       exec_strobe;
  logic [7:0] pc;
  logic       halted;

  int vectors;
  int miscompares;

  instr_fetch_unit #(
    .ADDR_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .pc_en       (pc_en),
    .jmp         (jmp),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .instr_valid (instr_valid),
    .exec_strobe (exec_strobe),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH with stall low; ends one edge after EXEC.
  task automatic do_instr(input logic [15:0] word, input logic j, input logic e);
    tick();
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    tick();
    jmp   = j;
    pc_en = e;
    tick();
    jmp   = 1'b0;
    pc_en = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = 16'h0000;
    pc_en       = 1'b0;
    jmp         = 1'b0;
    tick();
    tick();
    chk("rst_req",    {15'd0, imem_req},    16'd0);
    chk("rst_ivalid", {15'd0, instr_valid}, 16'd0);
    chk("rst_exec",   {15'd0, exec_strobe}, 16'd0);
    chk("rst_halted", {15'd0, halted},      16'd0);
    chk("rst_pc",     {8'd0, pc},           16'h0000);
    chk("rst_ir",     {opcode, rd, rs1, rs2}, 16'h0000);

    // First instruction 16'h1123 at address 0
    rst = 1'b0;
    #1;
    chk("c1_req",  {15'd0, imem_req}, 16'd1);
    chk("c1_addr", {8'd0, imem_addr}, 16'h0000);
    tick();
    chk("c2_req",    {15'd0, imem_req},    16'd0);
    chk("c2_ivalid", {15'd0, instr_valid}, 16'd0);
    imem_valid = 1'b1;
    imem_rdata = 16'h1123;
    tick();
    imem_valid = 1'b0;
    chk("c3_ivalid", {15'd0, instr_valid}, 16'd1);
    chk("c3_exec",   {15'd0, exec_strobe}, 16'd0);
    chk("c3_fields", {opcode, rd, rs1, rs2}, 16'h1123);
    tick();
    chk("c4_exec",   {15'd0, exec_strobe}, 16'd1);
    chk("c4_pc",     {8'd0, pc},           16'h0000);
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    chk("inc_pc",   {8'd0, pc},           16'h0001);
    chk("inc_req",  {15'd0, imem_req},    16'd1);
    chk("inc_addr", {8'd0, imem_addr},    16'h0001);
    chk("inc_ival", {15'd0, instr_valid}, 16'd0);

    // Jump beats increment
    do_instr(16'hF042, 1'b1, 1'b1);
    chk("jmp_pc",   {8'd0, pc},        16'h0042);
    chk("jmp_addr", {8'd0, imem_addr}, 16'h0042);
    chk("jmp_req",  {15'd0, imem_req}, 16'd1);

    // Wrap from all-ones
    do_instr(16'hF0FF, 1'b1, 1'b0);
    chk("pre_wrap_pc", {8'd0, pc}, 16'h00FF);
    do_instr(16'h2345, 1'b0, 1'b1);
    chk("wrap_pc", {8'd0, pc}, 16'h0000);

    // Neither jmp nor pc_en: same address refetched
    do_instr(16'h2007, 1'b0, 1'b0);
    chk("hold_pc",   {8'd0, pc},        16'h0000);
    chk("hold_addr", {8'd0, imem_addr}, 16'h0000);
    chk("hold_req",  {15'd0, imem_req}, 16'd1);

    // Stall in FETCH for three cycles
    stall = 1'b1;
    #1;
    chk("stall0_req", {15'd0, imem_req}, 16'd0);
    tick();
    chk("stall1_req", {15'd0, imem_req}, 16'd0);
    tick();
    chk("stall2_req", {15'd0, imem_req}, 16'd0);
    stall = 1'b0;
    #1;
    chk("unstall_req", {15'd0, imem_req}, 16'd1);

    // Slow memory: five WAIT cycles, stall in WAIT has no effect
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("slow_ivalid", {15'd0, instr_valid}, 16'd0);
      chk("slow_req",    {15'd0, imem_req},    16'd0);
      tick();
    end
    stall      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'h3456;
    tick();
    chk("slow_ival_dec", {15'd0, instr_valid}, 16'd1);
    chk("slow_fields",   {opcode, rd, rs1, rs2}, 16'h3456);
    imem_rdata = 16'hABCD;
    tick();
    imem_valid = 1'b0;
    chk("stray_fields", {opcode, rd, rs1, rs2}, 16'h3456);
    chk("stray_exec",   {15'd0, exec_strobe},   16'd1);
    tick();
    chk("slow_pc", {8'd0, pc}, 16'h0000);

    // Reset in WAIT with a late imem_valid
    do_instr(16'hF020, 1'b1, 1'b0);
    chk("pre_rst_pc", {8'd0, pc}, 16'h0020);
    tick();
    chk("wait_req", {15'd0, imem_req}, 16'd0);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    stall      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    imem_valid = 1'b0;
    chk("mid_rst_ir",     {opcode, rd, rs1, rs2}, 16'h0000);
    chk("mid_rst_pc",     {8'd0, pc},             16'h0000);
    chk("mid_rst_ivalid", {15'd0, instr_valid},   16'd0);
    stall = 1'b0;
    #1;
    chk("mid_rst_req",  {15'd0, imem_req}, 16'd1);
    chk("mid_rst_addr", {8'd0, imem_addr}, 16'h0000);

    // Self-jump at 8'h10
    do_instr(16'hF010, 1'b1, 1'b0);
    chk("sj_pc", {8'd0, pc}, 16'h0010);
    do_instr(16'hF010, 1'b1, 1'b0);
`ifdef HALT_ON_SELF_JUMP_EN
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag",   {15'd0, halted},      16'd1);
      chk("halt_req",    {15'd0, imem_req},    16'd0);
      chk("halt_ivalid", {15'd0, instr_valid}, 16'd0);
      tick();
    end
    chk("halt_pc", {8'd0, pc}, 16'h0010);
`else
    for (int n = 0; n < 3; n++) begin
      chk("sj_req",    {15'd0, imem_req}, 16'd1);
      chk("sj_addr",   {8'd0, imem_addr}, 16'h0010);
      chk("sj_halted", {15'd0, halted},   16'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
        chk("sj_gap_req", {15'd0, imem_req}, 16'd0);
        if (i == 0) begin
          imem_valid = 1'b1;
          imem_rdata = 16'hF010;
        end else if (i == 1) begin
          imem_valid = 1'b0;
          jmp        = 1'b1;
        end
        tick();
      end
      jmp = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
